// File: rtl/fft_pkg.sv
// Shared constants and types for the fft_8 streaming front end.
package fft_pkg;

   localparam int FFT_POINTS         = 8;
   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef struct packed {
      logic signed [DEFAULT_DATA_WIDTH-1:0] re;
      logic signed [DEFAULT_DATA_WIDTH-1:0] im;
   } cplx_t;

   typedef logic [1:0] loader_state_t;
   localparam loader_state_t IDLE = 2'd0;
   localparam loader_state_t RUN  = 2'd1;
   localparam loader_state_t GAP  = 2'd2;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream in, parallel frame out, plus the fft_8 start/done pair.
interface fft_frame_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // A sample transfers on a rising clk edge where in_valid && in_ready; the
   // source must hold in_real/in_imag stable while in_valid is high and in_ready is low.
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_real;
   logic signed [DATA_WIDTH-1:0] in_imag;
   logic signed [DATA_WIDTH-1:0] frame_real [0:7];
   logic signed [DATA_WIDTH-1:0] frame_imag [0:7];
   logic                         start_fft;
   logic                         fft_done;
   logic [CW-1:0]                fill_level;
   logic                         err_timeout;

   modport master (
      output in_valid, in_real, in_imag, fft_done,
      input  in_ready, frame_real, frame_imag, start_fft, fill_level, err_timeout
   );

   modport slave (
      input  in_valid, in_real, in_imag, fft_done,
      output in_ready, frame_real, frame_imag, start_fft, fill_level, err_timeout
   );

endinterface

// File: rtl/fft_sample_ring.sv
// Circular sample store; exposes the 8 oldest entries as a combinational window.
module fft_sample_ring
   import fft_pkg::*;
#(
   parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int  DEPTH      = 16,
   localparam int AW         = $clog2(DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic signed [DATA_WIDTH-1:0] wr_re,
   input  logic signed [DATA_WIDTH-1:0] wr_im,
   input  logic                         rel,
   output logic [CW-1:0]                fill_level,
   output logic signed [DATA_WIDTH-1:0] win_re [0:FFT_POINTS-1],
   output logic signed [DATA_WIDTH-1:0] win_im [0:FFT_POINTS-1]
);

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] re;
      logic signed [DATA_WIDTH-1:0] im;
   } slot_t;

   slot_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{re: wr_re, im: wr_im};
      end
   end

   // Pointers are AW bits wide, so the additions wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (rel)  rd_ptr <= rd_ptr + AW'(FFT_POINTS);
         fill_level <= fill_level + CW'(push) - (rel ? CW'(FFT_POINTS) : CW'(0));
      end
   end

   always_comb begin
      for (int i = 0; i < FFT_POINTS; i++) begin
         win_re[i] = mem[rd_ptr + AW'(i)].re;
         win_im[i] = mem[rd_ptr + AW'(i)].im;
      end
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Buffers streamed samples and hands 8-sample frames to fft_8 (IDLE -> RUN -> GAP).
// Build with FRAME_LOADER_TIMEOUT_EN defined to bound RUN by TIMEOUT_CYCLES.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int  DEPTH          = 16,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int CW             = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   fft_frame_loader_if.slave bus,
   output loader_state_t state
);

   logic                         ready;
   logic                         push;
   logic                         rel;
   logic                         timeout_hit;
   logic                         start_q;
   logic [CW-1:0]                fill_level;
   logic signed [DATA_WIDTH-1:0] win_re   [0:FFT_POINTS-1];
   logic signed [DATA_WIDTH-1:0] win_im   [0:FFT_POINTS-1];
   logic signed [DATA_WIDTH-1:0] frame_re [0:FFT_POINTS-1];
   logic signed [DATA_WIDTH-1:0] frame_im [0:FFT_POINTS-1];
   loader_state_t                state_q;
   loader_state_t                state_d;

   fft_sample_ring #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ring (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .wr_re      (bus.in_real),
      .wr_im      (bus.in_imag),
      .rel        (rel),
      .fill_level (fill_level),
      .win_re     (win_re),
      .win_im     (win_im)
   );

   // Readiness looks only at the registered count, never at this cycle's release.
   assign ready          = (fill_level < CW'(DEPTH));
   assign push           = bus.in_valid && ready;
   assign rel            = (state_q == GAP);
   assign bus.in_ready   = ready;
   assign bus.fill_level = fill_level;
   assign bus.start_fft  = start_q;
   assign bus.frame_real = frame_re;
   assign bus.frame_imag = frame_im;
   assign state          = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fill_level >= CW'(FFT_POINTS)) state_d = RUN;
         RUN:     if (bus.fft_done || timeout_hit) state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         for (int i = 0; i < FFT_POINTS; i++) begin
            frame_re[i] <= '0;
            frame_im[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         start_q <= (state_d == RUN);
         if (state_q == IDLE && state_d == RUN) begin
            frame_re <= win_re;
            frame_im <= win_im;
         end
      end
   end

`ifdef FRAME_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] run_cnt;
   logic          err_q;

   // run_cnt holds the number of RUN cycles already completed in this frame.
   assign timeout_hit     = (state_q == RUN) && !bus.fft_done &&
                            (run_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign bus.err_timeout = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         run_cnt <= (state_q == RUN) ? run_cnt + TW'(1) : '0;
         if (timeout_hit) err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit     = (TIMEOUT_CYCLES < 0);
   assign bus.err_timeout = 1'b0;
`endif

endmodule
